// File: rtl/reg_dump_reader.sv
// reg_dump_reader: walks a register-file address range and streams each value over valid/ready
module reg_dump_reader #(
  parameter int ADDR_W = 5,
  parameter int DATA_W = 32
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              iStart,
  input  logic [ADDR_W-1:0] iFirst,
  input  logic [ADDR_W-1:0] iLast,
  input  logic              iAbort,
  output logic              oBusy,
  output logic              oRdE,
  output logic [ADDR_W-1:0] oRdAddr,
  input  logic [DATA_W-1:0] iRdData,
  output logic              oValid,
  input  logic              iReady,
  output logic [DATA_W-1:0] oData,
  output logic [ADDR_W-1:0] oAddr,
  output logic              oLast,
  output logic              oDone
);
  typedef enum logic [1:0] {IDLE, READ, SEND, DONE} state_e;
  state_e            state_q, state_d;
  logic [ADDR_W-1:0] cur_q, cur_d, last_q, last_d, addr_q, addr_d;
  logic [DATA_W-1:0] data_q, data_d;
  logic              lst_q, lst_d;
  // state and datapath registers, cleared asynchronously
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      cur_q   <= '0;
      last_q  <= '0;
      addr_q  <= '0;
      data_q  <= '0;
      lst_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cur_q   <= cur_d;
      last_q  <= last_d;
      addr_q  <= addr_d;
      data_q  <= data_d;
      lst_q   <= lst_d;
    end
  end
  // next state; read data is captured only in READ so an undriven bus is never sampled
  always_comb begin
    state_d = state_q;
    cur_d   = cur_q;
    last_d  = last_q;
    addr_d  = addr_q;
    data_d  = data_q;
    lst_d   = lst_q;
    case (state_q)
      IDLE: if (iStart) begin
        cur_d   = iFirst;
        last_d  = iLast;
        state_d = READ;
      end
      READ: if (iAbort) state_d = IDLE;
      else begin
        data_d  = iRdData;
        addr_d  = cur_q;
        lst_d   = cur_q == last_q;
        state_d = SEND;
      end
      SEND: if (iAbort) state_d = IDLE;
      else if (iReady) begin
        state_d = lst_q ? DONE : READ;
        cur_d   = lst_q ? cur_q : cur_q + ADDR_W'(1);
      end
      default: state_d = IDLE;
    endcase
  end
  // outputs decoded from the current state; read address always follows cur
  always_comb begin
    oBusy   = state_q != IDLE;
    oRdE    = state_q == READ;
    oValid  = state_q == SEND;
    oDone   = state_q == DONE;
    oRdAddr = cur_q;
    oData   = data_q;
    oAddr   = addr_q;
    oLast   = lst_q;
  end
endmodule
